// File: rtl/da_bitplane_reader.sv
// da_bitplane_reader: captures a full sample window from the ping-pong buffer
// and streams it to the DA engine as LSB-first bit-planes.
module da_bitplane_reader #(
    parameter int TAPS       = 128,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = $clog2(DATA_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [TAPS*DATA_WIDTH-1:0] window_in,
    input  logic                       window_valid,
    output logic                       start_computation,
    output logic [TAPS-1:0]            slice_out,
    output logic                       slice_valid,
    input  logic                       slice_ready,
    output logic [IDX_W-1:0]           plane_idx,
    output logic                       slice_sign,
    output logic                       window_done,
    output logic                       busy,
    output logic [15:0]                windows_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [TAPS*DATA_WIDTH-1:0] r_hold;
    logic [TAPS*DATA_WIDTH-1:0] w_hold_nxt;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           w_idx_nxt;
    logic [TAPS-1:0]            r_slice;
    logic [TAPS-1:0]            w_slice_nxt;
    logic                       r_armed;
    logic                       r_valid;
    logic                       r_sign;
    logic                       r_start;
    logic                       r_done;
    logic                       r_busy;
    logic [15:0]                r_count;
    logic                       w_capture;
    logic                       w_streaming_nxt;

    // Gather bit k of every tap into one plane.
    function automatic logic [TAPS-1:0] bitplane(
        input logic [TAPS*DATA_WIDTH-1:0] w,
        input logic [IDX_W-1:0]           k
    );
        logic [TAPS-1:0] p;
        p = '0;
        for (int i = 0; i < TAPS; i++) begin
            p[i] = w[i*DATA_WIDTH + int'(k)];
        end
        return p;
    endfunction

    assign w_capture = (r_state == S_IDLE) && window_valid && r_armed;

    // Next-state and next plane index.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        unique case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = S_STREAM;
                    w_idx_nxt   = '0;
                end
            end
            S_STREAM: begin
                if (slice_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next holding word and next plane; the plane comes from the
    // captured copy so later window_in changes cannot leak in.
    always_comb begin
        w_hold_nxt      = r_hold;
        w_streaming_nxt = (w_state_nxt == S_STREAM);
        if (w_capture) begin
            w_hold_nxt = window_in;
        end
        w_slice_nxt = '0;
        if (w_streaming_nxt) begin
            w_slice_nxt = bitplane(w_hold_nxt, w_idx_nxt);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold  <= '0;
            r_idx   <= '0;
            r_slice <= '0;
            r_valid <= 1'b0;
            r_sign  <= 1'b0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_hold  <= w_hold_nxt;
            r_idx   <= w_idx_nxt;
            r_slice <= w_slice_nxt;
            r_valid <= w_streaming_nxt;
            r_sign  <= w_streaming_nxt && (w_idx_nxt == LAST_IDX);
            r_start <= w_capture;
            r_done  <= (w_state_nxt == S_DONE);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Arm tracking: a level-held window is captured only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b1;
        end else if (!window_valid) begin
            r_armed <= 1'b1;
        end else if (w_capture) begin
            r_armed <= 1'b0;
        end
    end

    // Completed-window counter, bumped on the edge leaving DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_state == S_DONE) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign start_computation = r_start;
    assign slice_out         = r_slice;
    assign slice_valid       = r_valid;
    assign plane_idx         = r_idx;
    assign slice_sign        = r_sign;
    assign window_done       = r_done;
    assign busy              = r_busy;
    assign windows_count     = r_count;

endmodule

// File: tb/tb_da_bitplane_reader.sv
// tb_da_bitplane_reader: directed vector bench for da_bitplane_reader
// with TAPS=4, DATA_WIDTH=4.
module tb_da_bitplane_reader;

    localparam int TAPS = 4;
    localparam int DW   = 4;
    localparam int IW   = 2;

    logic           clk;
    logic           rst_n;
    logic [15:0]    window_in;
    logic           window_valid;
    logic           start_computation;
    logic [3:0]     slice_out;
    logic           slice_valid;
    logic           slice_ready;
    logic [IW-1:0]  plane_idx;
    logic           slice_sign;
    logic           window_done;
    logic           busy;
    logic [15:0]    windows_count;

    int n_chk  = 0;
    int n_pass = 0;

    da_bitplane_reader #(
        .TAPS(TAPS),
        .DATA_WIDTH(DW),
        .IDX_W(IW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .window_in(window_in),
        .window_valid(window_valid),
        .start_computation(start_computation),
        .slice_out(slice_out),
        .slice_valid(slice_valid),
        .slice_ready(slice_ready),
        .plane_idx(plane_idx),
        .slice_sign(slice_sign),
        .window_done(window_done),
        .busy(busy),
        .windows_count(windows_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vin;
        logic       rdy;
        logic       st;
        logic       sv;
        logic [3:0] sl;
        logic [1:0] idx;
        logic       sg;
        logic       dn;
        logic       bz;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(
        input logic vin, input logic rdy, input logic st,
        input logic sv, input logic [3:0] sl, input logic [1:0] idx,
        input logic sg, input logic dn, input logic bz
    );
        vec_t v;
        v.vin = vin; v.rdy = rdy; v.st = st; v.sv = sv; v.sl = sl;
        v.idx = idx; v.sg = sg; v.dn = dn; v.bz = bz;
        return v;
    endfunction

    // Bit k of each of the four 4-bit samples.
    function automatic logic [3:0] pl(input logic [15:0] w, input int k);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = w[i*4 + k];
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] wins[3];
    int          starts;
    int          p;
    int          w;

    initial begin
        rst_n        = 1'b0;
        window_in    = 16'h8421;
        window_valid = 1'b0;
        slice_ready  = 1'b1;
        #12;
        chk("rst_start", 32'(start_computation), 32'd0);
        chk("rst_valid", 32'(slice_valid), 32'd0);
        chk("rst_slice", 32'(slice_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(windows_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic stream then backpressure on plane 2.
        tbl[0]  = mk(1, 1, 1, 1, 4'b0001, 0, 0, 0, 1);
        tbl[1]  = mk(0, 1, 0, 1, 4'b0010, 1, 0, 0, 1);
        tbl[2]  = mk(0, 1, 0, 1, 4'b0100, 2, 0, 0, 1);
        tbl[3]  = mk(0, 1, 0, 1, 4'b1000, 3, 1, 0, 1);
        tbl[4]  = mk(0, 1, 0, 0, 4'b0000, 0, 0, 1, 1);
        tbl[5]  = mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
        tbl[6]  = mk(1, 1, 1, 1, 4'b0001, 0, 0, 0, 1);
        tbl[7]  = mk(0, 1, 0, 1, 4'b0010, 1, 0, 0, 1);
        tbl[8]  = mk(0, 1, 0, 1, 4'b0100, 2, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 1, 4'b0100, 2, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 1, 4'b0100, 2, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 1, 4'b0100, 2, 0, 0, 1);
        tbl[12] = mk(0, 1, 0, 1, 4'b1000, 3, 1, 0, 1);
        tbl[13] = mk(0, 1, 0, 0, 4'b0000, 0, 0, 1, 1);
        tbl[14] = mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            window_valid = tbl[i].vin;
            slice_ready  = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_start", i), 32'(start_computation), 32'(tbl[i].st));
            chk($sformatf("v%0d_valid", i), 32'(slice_valid), 32'(tbl[i].sv));
            chk($sformatf("v%0d_sign", i), 32'(slice_sign), 32'(tbl[i].sg));
            chk($sformatf("v%0d_done", i), 32'(window_done), 32'(tbl[i].dn));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
            if (tbl[i].sv) begin
                chk($sformatf("v%0d_slice", i), 32'(slice_out), 32'(tbl[i].sl));
                chk($sformatf("v%0d_idx", i), 32'(plane_idx), 32'(tbl[i].idx));
            end
            if (i == 5) chk("count_basic", 32'(windows_count), 32'd1);
        end
        chk("count_bp", 32'(windows_count), 32'd2);

        // Level-held window: one capture only.
        slice_ready  = 1'b1;
        window_valid = 1'b1;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (start_computation) starts++;
        end
        chk("level_starts", 32'(starts), 32'd1);
        chk("level_count", 32'(windows_count), 32'd3);
        chk("level_idle", 32'(busy), 32'd0);
        window_valid = 1'b0;
        step();
        window_valid = 1'b1;
        step();
        chk("rearm_start", 32'(start_computation), 32'd1);
        window_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("rearm_count", 32'(windows_count), 32'd4);

        // Input isolation.
        window_valid = 1'b1;
        step();
        chk("iso_p0", 32'(slice_out), 32'(pl(16'h8421, 0)));
        window_valid = 1'b0;
        window_in    = 16'hFFFF;
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("iso_p%0d", k), 32'(slice_out), 32'(pl(16'h8421, k)));
        end
        step();
        step();
        window_in = 16'h8421;
        chk("iso_count", 32'(windows_count), 32'd5);

        // Reset mid-stream during plane 1.
        window_valid = 1'b1;
        step();
        window_valid = 1'b0;
        step();
        chk("pre_rst_idx", 32'(plane_idx), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(slice_valid), 32'd0);
        chk("arst_slice", 32'(slice_out), 32'd0);
        chk("arst_idx", 32'(plane_idx), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(window_done), 32'd0);
        chk("arst_count", 32'(windows_count), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_count", 32'(windows_count), 32'd0);
        window_valid = 1'b1;
        step();
        chk("post_rst_start", 32'(start_computation), 32'd1);
        chk("post_rst_idx", 32'(plane_idx), 32'd0);
        chk("post_rst_p0", 32'(slice_out), 32'(pl(16'h8421, 0)));
        window_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("post_rst_p%0d", k), 32'(slice_out), 32'(pl(16'h8421, k)));
        end
        step();
        chk("post_rst_done", 32'(window_done), 32'd1);
        step();
        chk("post_rst_cnt1", 32'(windows_count), 32'd1);

        // Back-to-back windows at the minimum period of 6 cycles.
        wins[0] = 16'h8421;
        wins[1] = 16'hFFFF;
        wins[2] = 16'h1248;
        window_in = wins[0];
        for (int c = 0; c < 18; c++) begin
            p = c % 6;
            w = c / 6;
            window_valid = (p != 1);
            step();
            chk($sformatf("b2b%0d_start", c), 32'(start_computation), 32'(p == 0));
            if (p < 4) begin
                chk($sformatf("b2b%0d_valid", c), 32'(slice_valid), 32'd1);
                chk($sformatf("b2b%0d_slice", c), 32'(slice_out), 32'(pl(wins[w], p)));
                chk($sformatf("b2b%0d_idx", c), 32'(plane_idx), 32'(p));
            end else if (p == 4) begin
                chk($sformatf("b2b%0d_done", c), 32'(window_done), 32'd1);
            end else begin
                chk($sformatf("b2b%0d_busy", c), 32'(busy), 32'd0);
            end
            if (p == 0 && w < 2) window_in = wins[w+1];
        end
        window_valid = 1'b0;
        step();
        chk("b2b_count", 32'(windows_count), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
